ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit. Sits directly upstream of the next-PC unit and feeds it.
//  - Owns the architectural fetch PC and issues word fetches to instruction memory.
//  - Buffers returned words with their PC and presents {instr, instr_pc} to decode.
//  - Accepts redirect targets computed by the next-PC unit (j/jal/jr/taken beq).
// PARAMETERS
//  RESET_PC   32'h0000_3000  fetch PC after reset
//  FIFO_DEPTH 2              instr/pc buffer entries; power of 2, >=2
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous reset, active low
//  redirect       in   1   load npc as new fetch PC, flush buffer
//  npc            in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request
//  imem_addr      out  32  word address of request (fetch PC)
//  imem_rsp_valid in   1   response data valid; at most one per accepted request, in order
//  imem_rsp_data  in   32  instruction word
//  instr_valid    out  1   buffer head valid toward decode
//  instr_ready    in   1   decode consumes head
//  instr          out  32  head instruction
//  instr_pc       out  32  PC of head instruction (drives next-PC unit pc input)
// BEHAVIOUR
//  Reset (async, rst_n=0): fetch_pc=RESET_PC, state=IDLE, buffer empty.
//   Outputs: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=RESET_PC, imem_addr=RESET_PC.
//  FSM (at most one outstanding request):
//   IDLE: go REQ when credits>0; credits = FIFO_DEPTH - occupancy - outstanding.
//   REQ : imem_req_valid=1, imem_addr=fetch_pc; hold stable until ready.
//         On req_valid&ready: fetch_pc += 4 (32-bit wrap), go WAIT.
//   WAIT: on rsp_valid push {rsp_data, pc_of_req}, go REQ if credits remain, else IDLE.
//   DROP: outstanding rsp belongs to flushed path; on rsp_valid discard, go REQ.
//  Latency: first instr_valid >= 2 cycles after request accept; buffer push->head 1 cycle.
//   Back-to-back throughput 1 word/2 cycles with 1-cycle memory.
//  Buffer: FIFO of {instr, pc}; instr_valid = !empty; pop on instr_valid&instr_ready.
//   Full: no new request issued (credit rule); push never overflows.
//   Simultaneous push+pop: occupancy unchanged, order preserved.
//   Pointers wrap modulo FIFO_DEPTH.
//  Redirect (cycle t, registered effect at t+1):
//   fetch_pc <= {npc[31:2], 2'b00}; buffer flushed; instr_valid=0 at t+1.
//   If request outstanding (WAIT, or REQ handshake in cycle t) -> DROP, else -> REQ.
//   Redirect beats simultaneous pop and simultaneous push: both discarded.
//   A rsp_valid arriving in cycle t is discarded.
//   Redirect while in DROP: update fetch_pc, stay DROP (one stale rsp still pending).
//  imem_req_valid never drops once raised until accepted, except on redirect or reset.
//  Reset mid-operation: all state cleared immediately; any later stale rsp_valid
//   while IDLE/REQ is ignored.
//  instr_pc when buffer empty holds last head value (RESET_PC after reset).
// STRUCTURE
//  Shared package (cpu_pkg): RESET_PC constant, FSM state enum
//   {IDLE, REQ, WAIT, DROP}, PC_STEP = 32'd4.
//  One sub-module: ifu_fifo (sync FIFO, width 64, depth FIFO_DEPTH, flush input,
//   async active-low reset). Fetch FSM, fetch_pc, credit logic in ifu_fetch.
// TESTING
//  1 Reset release, mem ready=1, 1-cycle rsp: addrs 0x3000,0x3004,0x3008 issued;
//    decode sees instr_pc 0x3000.. in order with matching words.
//  2 instr_ready=0: after 2 words buffered imem_req_valid stays 0; raise ready
//    -> fetch resumes at 0x3008, no word lost or duplicated.
//  3 Redirect npc=0x0000_3100 while WAIT -> next rsp dropped, next req addr
//    0x3100, first instr_pc 0x3100; npc=0x3102 also yields 0x3100.
//  4 Redirect same cycle as pop and rsp_valid -> buffer empty next cycle,
//    popped/pushed words never reappear.
//  5 imem_req_ready=0 for 5 cycles -> req_valid and addr held stable;
//    fetch_pc at 0xFFFF_FFFC increments and wraps to 0x0000_0000.
//  6 rst_n low mid-WAIT then high -> req addr 0x3000; stale rsp ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path constants: reset PC, PC increment and fetch FSM state encodings.
package cpu_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DROP = 2'd3;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; when empty the head output keeps the last value it presented.
module ifu_fifo #(
    parameter int               DEPTH      = 2,
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? last_head : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= RESET_DATA;
        end else begin
            if (!empty) begin
                last_head <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one word request at a time and
// buffers returned words with their PC for decode. Redirects flush the buffer.
//
//  state | meaning
//  IDLE  | no request outstanding, waiting for buffer room
//  REQ   | request presented to imem, held until accepted
//  WAIT  | request accepted, response will be pushed into the buffer
//  DROP  | response outstanding for a flushed path, discard it
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] npc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    import cpu_pkg::*;

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW1 = CW + 1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic          empty;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          room_idle;
    logic          room_after_push;
    logic          still_pending;

    assign req_fire       = (state == REQ) && imem_req_ready;
    assign push           = (state == WAIT) && imem_rsp_valid && !redirect;
    assign pop            = !empty && instr_ready;
    assign imem_req_valid = (state == REQ);
    assign imem_addr      = fetch_pc;
    assign instr_valid    = !empty;
    assign instr          = head[63:32];
    assign instr_pc       = head[31:0];

    assign room_idle       = (count < CW'(FIFO_DEPTH));
    assign room_after_push = (({1'b0, count} + CW1'(1) - CW1'(pop)) < CW1'(FIFO_DEPTH));

    // A response arriving in the redirect cycle retires the outstanding request,
    // so only a still-missing response forces DROP.
    assign still_pending = req_fire ||
                           (((state == WAIT) || (state == DROP)) && !imem_rsp_valid);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (room_idle) state_nxt = REQ;
            REQ:     if (imem_req_ready) state_nxt = WAIT;
            WAIT:    if (imem_rsp_valid) state_nxt = room_after_push ? REQ : IDLE;
            DROP:    if (imem_rsp_valid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            state_nxt = still_pending ? DROP : REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= npc & ~32'h3;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
        end
    end

    ifu_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .WIDTH      (64),
        .RESET_DATA ({32'h0, RESET_PC})
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data ({imem_rsp_data, req_pc}),
        .pop       (pop),
        .head_data (head),
        .empty     (empty),
        .count     (count)
    );
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle-by-cycle vector table plus directed multi-cycle sequences.
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] npc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks   = 0;
    int failures = 0;

    // Memory model: either auto (1-cycle response) or manually driven.
    logic        mem_auto      = 1'b0;
    logic        man_rsp_valid = 1'b0;
    logic [31:0] man_rsp_data  = 32'h0;
    logic        fire_q        = 1'b0;
    logic [31:0] addr_q        = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) begin
        fire_q <= imem_req_valid && imem_req_ready;
        addr_q <= imem_addr;
    end

    assign imem_rsp_valid = mem_auto ? fire_q : man_rsp_valid;
    assign imem_rsp_data  = mem_auto ? word_of(addr_q) : man_rsp_data;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect       (redirect),
        .npc            (npc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic        rd;
        logic [31:0] npc;
        logic        rq_rdy;
        logic        rs_v;
        logic [31:0] rs_d;
        logic        in_rdy;
        logic        rq_v;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] ins;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic rd, input logic [31:0] n, input logic rq_rdy,
                                input logic rs_v, input logic [31:0] rs_d, input logic in_rdy,
                                input logic rq_v, input logic [31:0] addr, input logic iv,
                                input logic [31:0] ipc, input logic [31:0] ins);
        vec_t v;
        v.rd = rd; v.npc = n; v.rq_rdy = rq_rdy; v.rs_v = rs_v; v.rs_d = rs_d;
        v.in_rdy = in_rdy; v.rq_v = rq_v; v.addr = addr; v.iv = iv; v.ipc = ipc; v.ins = ins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; npc = 32'h0; imem_req_ready = 1'b0;
        instr_ready = 1'b0; mem_auto = 1'b0; man_rsp_valid = 1'b0; man_rsp_data = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0000_3000);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (imem_req_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Called at/near a negedge with instr_ready=1; checks n popped words in PC order.
    task automatic collect(input string name, input logic [31:0] first, input int n);
        logic [31:0] exp_pc;
        int got;
        exp_pc = first;
        got = 0;
        for (int c = 0; c < 40 * n && got < n; c++) begin
            #1;
            if (instr_valid) begin
                chk($sformatf("%s_pc%0d", name, got), instr_pc, exp_pc);
                chk($sformatf("%s_instr%0d", name, got), instr, word_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk);
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, got, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;

        // rd, npc, rq_rdy, rs_v, rs_d, in_rdy | rq_v, addr, iv, ipc, ins
        tbl[0]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h3000, 1'b0, 32'h3000, 32'h0);
        tbl[1]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3000, 1'b0, 32'h3000, 32'h0);
        tbl[2]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b1, 1'b0, 32'h3004, 1'b0, 32'h3000, 32'h0);
        tbl[3]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3004, 1'b1, 32'h3000, 32'hAAAA_0000);
        tbl[4]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB_0004, 1'b1, 1'b0, 32'h3008, 1'b0, 32'h3000, 32'hAAAA_0000);
        tbl[5]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3008, 1'b1, 32'h3004, 32'hBBBB_0004);
        tbl[6]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hCCCC_0008, 1'b1, 1'b0, 32'h300C, 1'b0, 32'h3004, 32'hBBBB_0004);
        tbl[7]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h300C, 1'b1, 32'h3008, 32'hCCCC_0008);
        tbl[8]  = mk(1'b1, 32'h3100, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h3010, 1'b1, 32'h3008, 32'hCCCC_0008);
        tbl[9]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0010, 1'b0, 1'b0, 32'h3100, 1'b0, 32'h3008, 32'hCCCC_0008);
        tbl[10] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h3100, 1'b0, 32'h3008, 32'hCCCC_0008);
        tbl[11] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_3100, 1'b0, 1'b0, 32'h3104, 1'b0, 32'h3008, 32'hCCCC_0008);
        tbl[12] = mk(1'b1, 32'h3102, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h3104, 1'b1, 32'h3100, 32'h1234_3100);
        tbl[13] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h3100, 1'b0, 32'h3100, 32'h1234_3100);
        tbl[14] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_3100, 1'b0, 1'b0, 32'h3104, 1'b0, 32'h3100, 32'h1234_3100);
        tbl[15] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h3104, 1'b1, 32'h3100, 32'h5555_3100);
        tbl[16] = mk(1'b1, 32'h3200, 1'b1, 1'b1, 32'h6666_3104, 1'b1, 1'b0, 32'h3108, 1'b1, 32'h3100, 32'h5555_3100);
        tbl[17] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3200, 1'b0, 32'h3100, 32'h5555_3100);
        tbl[18] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h7777_3200, 1'b1, 1'b0, 32'h3204, 1'b0, 32'h3100, 32'h5555_3100);
        tbl[19] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h3204, 1'b1, 32'h3200, 32'h7777_3200);

        // Vector table: fetch stream, redirect in WAIT, redirect in REQ, redirect with pop+rsp.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            redirect       = tbl[i].rd;
            npc            = tbl[i].npc;
            imem_req_ready = tbl[i].rq_rdy;
            man_rsp_valid  = tbl[i].rs_v;
            man_rsp_data   = tbl[i].rs_d;
            instr_ready    = tbl[i].in_rdy;
            #1;
            chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rq_v));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
            chk($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].ipc);
            chk($sformatf("v%0d_instr", i), instr, tbl[i].ins);
            @(negedge clk);
        end
        redirect = 1'b0;

        // Back-pressure: buffer fills, fetch stops, resumes at 0x3008 without loss.
        do_reset();
        mem_auto = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_no_req%0d", i), 32'(imem_req_valid), 32'h0);
            @(negedge clk);
            #1;
        end
        chk("bp_head_pc", instr_pc, 32'h3000);
        chk("bp_head_instr", instr, word_of(32'h3000));
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_req(ok);
        chk("bp_resume_seen", 32'(ok), 32'h1);
        chk("bp_resume_addr", imem_addr, 32'h3008);
        instr_ready = 1'b1;
        collect("bp", 32'h3004, 3);

        // Stalled memory holds the request; fetch PC wraps past 0xFFFF_FFFC.
        do_reset();
        imem_req_ready = 1'b0;
        wait_req(ok);
        chk("stall_req_seen", 32'(ok), 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid%0d", i), 32'(imem_req_valid), 32'h1);
            chk($sformatf("stall_addr%0d", i), imem_addr, 32'h3000);
            @(negedge clk);
            #1;
        end
        mem_auto = 1'b1;
        redirect = 1'b1;
        npc      = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        collect("wrap", 32'hFFFF_FFFC, 3);

        // Reset asserted mid-WAIT; stale responses afterwards are ignored.
        do_reset();
        mem_auto = 1'b1; imem_req_ready = 1'b1;
        wait_req(ok);
        chk("mrst_req_seen", 32'(ok), 32'h1);
        @(negedge clk);
        #1;
        chk("mrst_wait_valid", 32'(imem_req_valid), 32'h0);
        chk("mrst_wait_addr", imem_addr, 32'h3004);
        rst_n = 1'b0;
        mem_auto = 1'b0;
        man_rsp_valid = 1'b0;
        #1;
        chk("mrst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("mrst_addr", imem_addr, 32'h3000);
        chk("mrst_instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'hDEAD_BEEF;
        imem_req_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_req_after", 32'(imem_req_valid), 32'h1);
        chk("mrst_addr_after", imem_addr, 32'h3000);
        @(negedge clk);
        man_rsp_valid = 1'b0;
        #1;
        chk("mrst_stale_ignored", 32'(instr_valid), 32'h0);
        mem_auto = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        collect("mrst", 32'h3000, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
